// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - Q5.11 fixed-point types shared by the sigmoid stages and serializer
package sigmoid_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 11;

  typedef logic signed [Q_W-1:0] q5_11_t;

endpackage

// File: rtl/dw_sr_fifo.sv
// rtl/dw_sr_fifo.sv - dual-write single-read circular buffer with pair accept logic
module dw_sr_fifo
  import sigmoid_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  q5_11_t        wr_lo,
  input  q5_11_t        wr_hi,
  input  logic          rd_ready,
  output q5_11_t        rd_data,
  output logic          rd_valid,
  output logic [FW-1:0] fill,
  output logic [FW-1:0] fill_next,
  output logic          push,
  output logic          pop,
  output logic          drop
);

  localparam logic [FW:0] DEPTH_X = (FW + 1)'(DEPTH);
  localparam logic [FW:0] PAIR_X  = (FW + 1)'(2);

  q5_11_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_hi;
  logic [FW:0]   room;

  assign rd_valid  = (fill != '0);
  assign pop       = rd_valid && rd_ready;
  assign rd_data   = mem[rd_ptr];
  assign wr_ptr_hi = wr_ptr + AW'(1);

  // A pop in the same cycle frees a slot that the incoming pair may use.
  assign room = DEPTH_X - {1'b0, fill} + {{FW{1'b0}}, pop};
  assign push = wr_en && (room >= PAIR_X);
  assign drop = wr_en && !push;

  always_comb begin
    fill_next = fill;
    if (push) begin
      fill_next = fill_next + FW'(2);
    end
    if (pop) begin
      fill_next = fill_next - FW'(1);
    end
  end

  // Storage is never reset; y_valid gates its use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]    <= wr_lo;
      mem[wr_ptr_hi] <= wr_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(2);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/sigmoid_result_serializer.sv
// rtl/sigmoid_result_serializer.sv - serializes 2-lane sigmoid results onto one ready/valid stream
module sigmoid_result_serializer
  import sigmoid_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 10,
  parameter int IDX_W     = 16,
  localparam int FW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  q5_11_t           y0_in,
  input  q5_11_t           y1_in,
  input  logic             valid_in,
  output q5_11_t           y_out,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [FW-1:0]    fill,
  output logic             almost_full,
  output logic             overflow,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [FW-1:0] AF_LEVEL = FW'(AF_THRESH);

  logic [FW-1:0] fill_next;
  logic          push;
  logic          pop;
  logic          drop;

  dw_sr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (valid_in),
    .wr_lo     (y0_in),
    .wr_hi     (y1_in),
    .rd_ready  (y_ready),
    .rd_data   (y_out),
    .rd_valid  (y_valid),
    .fill      (fill),
    .fill_next (fill_next),
    .push      (push),
    .pop       (pop),
    .drop      (drop)
  );

  // almost_full tracks the registered fill, so it is derived from fill_next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      out_idx     <= '0;
    end else begin
      almost_full <= (fill_next >= AF_LEVEL);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        out_idx <= out_idx + IDX_W'(1);
      end
    end
  end

  logic unused_push;
  assign unused_push = push;

endmodule

// File: tb/tb_sigmoid_result_serializer.sv
// tb/tb_sigmoid_result_serializer.sv - randomized self-checking bench against a queue model
module tb_sigmoid_result_serializer;

  localparam int DEPTH = 16;
  localparam int AF    = 10;
  localparam int IDX_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] y0_in, y1_in, y_out;
  logic        valid_in, y_valid, y_ready;
  logic [4:0]  fill;
  logic        almost_full, overflow;
  logic [15:0] out_idx;

  always #5 clk = ~clk;

  sigmoid_result_serializer #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .y0_in       (y0_in),
    .y1_in       (y1_in),
    .valid_in    (valid_in),
    .y_out       (y_out),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .fill        (fill),
    .almost_full (almost_full),
    .overflow    (overflow),
    .out_idx     (out_idx)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic [15:0] out_log[$];
  logic [15:0] sent[$];
  bit          m_ovf;
  bit          m_af;
  int          m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs with the model, then step the model across one clock edge.
  task automatic cycle(input bit rst, input bit v, input logic [15:0] a, input logic [15:0] b,
                       input bit rdy);
    bit pop;
    rst_n    = !rst;
    valid_in = v;
    y0_in    = a;
    y1_in    = b;
    y_ready  = rdy;
    #3;
    check("y_valid", 32'(y_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("y_out", 32'(y_out), 32'(mq[0]));
    check("fill", 32'(fill), 32'(mq.size()));
    check("almost_full", 32'(almost_full), 32'(m_af));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("out_idx", 32'(out_idx), 32'(m_idx));
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_af  = 0;
      m_idx = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (v && (DEPTH - mq.size() + int'(pop) >= 2)) begin
        if (pop) begin
          out_log.push_back(mq.pop_front());
          m_idx = (m_idx + 1) % (1 << IDX_W);
        end
        mq.push_back(a);
        mq.push_back(b);
      end else begin
        if (v) m_ovf = 1;
        if (pop) begin
          out_log.push_back(mq.pop_front());
          m_idx = (m_idx + 1) % (1 << IDX_W);
        end
      end
      m_af = (mq.size() >= AF);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 16'h0, 16'h0, 1);
  endtask

  initial begin
    int   sent_pairs;
    int   budget;
    bit   v;
    bit   seen_bad;
    logic [15:0] a, b;
    int   sig[40];

    rst_n = 1'b0; valid_in = 1'b0; y0_in = '0; y1_in = '0; y_ready = 1'b0;
    mq.delete(); m_ovf = 0; m_af = 0; m_idx = 0;
    @(posedge clk);
    #1;
    cycle(1, 0, 16'h0, 16'h0, 0);

    // single pair, lane order and latency
    out_log.delete();
    cycle(0, 1, 16'h0400, 16'h0C00, 1);
    check("t1_first_valid", 32'(y_valid), 32'd1);
    check("t1_first_data", 32'(y_out), 32'h0400);
    drain(3);
    check("t1_count", 32'(out_log.size()), 32'd2);
    if (out_log.size() >= 2) begin
      check("t1_lane0", 32'(out_log[0]), 32'h0400);
      check("t1_lane1", 32'(out_log[1]), 32'h0C00);
    end
    check("t1_idx", 32'(out_idx), 32'd2);

    // backpressure fill to full, then an overflowing pair
    out_log.delete();
    for (int i = 0; i < 8; i++) cycle(0, 1, 16'($urandom), 16'($urandom), 0);
    check("t2_full", 32'(fill), 32'd16);
    check("t2_af", 32'(almost_full), 32'd1);
    cycle(0, 1, 16'hDEAD, 16'hBEEF, 0);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_fill_hold", 32'(fill), 32'd16);
    drain(17);
    seen_bad = 0;
    foreach (out_log[i]) if (out_log[i] == 16'hDEAD || out_log[i] == 16'hBEEF) seen_bad = 1;
    check("t2_dropped_absent", 32'(seen_bad), 32'd0);
    check("t2_count", 32'(out_log.size()), 32'd16);
    cycle(1, 0, 16'h0, 16'h0, 0);

    // simultaneous push+pop at fill=15 and at fill=16
    for (int i = 0; i < 8; i++) cycle(0, 1, 16'($urandom), 16'($urandom), 0);
    cycle(0, 0, 16'h0, 16'h0, 1);
    check("t3_fill15", 32'(fill), 32'd15);
    cycle(0, 1, 16'h1234, 16'h5678, 1);
    check("t3_fill16", 32'(fill), 32'd16);
    check("t3_no_ovf", 32'(overflow), 32'd0);
    cycle(0, 1, 16'h9ABC, 16'hDEF0, 1);
    check("t3_drop_fill", 32'(fill), 32'd15);
    check("t3_drop_ovf", 32'(overflow), 32'd1);
    drain(16);
    cycle(1, 0, 16'h0, 16'h0, 0);

    // random traffic across pointer wrap, upstream obeying almost_full
    out_log.delete();
    sent.delete();
    sent_pairs = 0;
    budget = 0;
    while ((sent_pairs < 100 || mq.size() != 0) && budget < 5000) begin
      v = (sent_pairs < 100) && !almost_full && ($urandom_range(1) == 1);
      a = 16'($urandom);
      b = 16'($urandom);
      if (v) begin
        sent.push_back(a);
        sent.push_back(b);
        sent_pairs++;
      end
      cycle(0, v, a, b, $urandom_range(1) == 1);
      budget++;
    end
    check("t4_budget", 32'(budget < 5000), 32'd1);
    check("t4_count", 32'(out_log.size()), 32'd200);
    check("t4_ovf", 32'(overflow), 32'd0);
    if (out_log.size() == sent.size())
      foreach (sent[i]) check("t4_stream", 32'(out_log[i]), 32'(sent[i]));

    // reset mid-stream at fill=7
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'($urandom), 16'($urandom), 0);
    cycle(0, 0, 16'h0, 16'h0, 1);
    check("t5_fill7", 32'(fill), 32'd7);
    cycle(1, 1, 16'h1111, 16'h2222, 1);
    check("t5_valid", 32'(y_valid), 32'd0);
    check("t5_fill", 32'(fill), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    check("t5_idx", 32'(out_idx), 32'd0);
    out_log.delete();
    cycle(0, 1, 16'h0800, 16'hF800, 0);
    drain(3);
    check("t5_count", 32'(out_log.size()), 32'd2);
    if (out_log.size() >= 2) begin
      check("t5_lane0", 32'(out_log[0]), 32'h0800);
      check("t5_lane1", 32'(out_log[1]), 32'hF800);
    end

    // sigmoid sweep over -10..10 in Q5.11
    for (int i = 0; i < 40; i++) begin
      real x;
      x = -10.0 + 20.0 * real'(i) / 39.0;
      sig[i] = $rtoi(2048.0 / (1.0 + $exp(-x)) + 0.5);
    end
    out_log.delete();
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 16'(sig[2*k]), 16'(sig[2*k+1]), $urandom_range(1) == 1);
      cycle(0, 0, 16'h0, 16'h0, 1);
    end
    drain(40);
    check("t6_count", 32'(out_log.size()), 32'd40);
    if (out_log.size() == 40) begin
      for (int i = 0; i < 40; i++) begin
        check("t6_order", 32'(out_log[i]), 32'(sig[i]));
        check("t6_range", 32'($signed(out_log[i]) >= 0 && $signed(out_log[i]) <= 2048), 32'd1);
        if (i > 0) check("t6_mono", 32'($signed(out_log[i]) >= $signed(out_log[i-1])), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
